// File: rtl/io_arbiter.sv
// Two-port round-robin arbiter sharing the io peripheral port; fixed-length transactions with ack.
// Define IOARB_PRIO_EN to replace round-robin with fixed priority (port 0 wins ties in IDLE).
module io_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int IO_LAT = 1
) (
   input  logic              clk,
   input  logic              sync_rst,
   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_data,
   output logic              io_write,
   input  logic [DATA_W-1:0] io_data_out,
   output logic              busy,
   output logic              grant_id
);

   generate
      if (IO_LAT < 1 || IO_LAT > 15) begin : g_lat_check
         $error("io_arbiter: IO_LAT must be in the range 1..15");
      end
   endgenerate

   localparam logic [3:0] LAT4 = 4'(IO_LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                grant_id_q, grant_id_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   io_addr_q, io_addr_d;
   logic [DATA_W-1:0]   io_data_q, io_data_d;
   logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
   logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;
`ifndef IOARB_PRIO_EN
   logic                last_grant_q, last_grant_d;
`endif

   logic                idle_win;
   logic                do_grant;
   logic                grant_sel;
   logic                other_id;

   // IDLE winner: a lone requester wins; ties go to the port that did not win last time
   always_comb begin
      idle_win = r1_req;
      if (r0_req && r1_req) begin
`ifdef IOARB_PRIO_EN
         idle_win = 1'b0;
`else
         idle_win = ~last_grant_q;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grant_id_d = grant_id_q;
      write_d    = write_q;
      io_addr_d  = io_addr_q;
      io_data_d  = io_data_q;
      r0_rdata_d = r0_rdata_q;
      r1_rdata_d = r1_rdata_q;
`ifndef IOARB_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      do_grant  = 1'b0;
      grant_sel = idle_win;
      other_id  = ~grant_id_q;

      case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               do_grant  = 1'b1;
               grant_sel = idle_win;
            end
         end
         ISSUE: begin
            cnt_d   = LAT4;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 4'd1) begin
               if (!write_q) begin
                  if (grant_id_q) r1_rdata_d = io_data_out;
                  else            r0_rdata_d = io_data_out;
               end
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            // The port being acked is ignored here, so the other port can follow without an IDLE gap
            if (other_id ? r1_req : r0_req) begin
               do_grant  = 1'b1;
               grant_sel = other_id;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_grant) begin
         state_d    = ISSUE;
         grant_id_d = grant_sel;
         write_d    = grant_sel ? r1_write : r0_write;
         io_addr_d  = grant_sel ? r1_addr  : r0_addr;
         io_data_d  = grant_sel ? r1_wdata : r0_wdata;
`ifndef IOARB_PRIO_EN
         last_grant_d = grant_sel;
`endif
      end
   end

   always_ff @(posedge clk or posedge sync_rst) begin
      if (sync_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         grant_id_q <= 1'b0;
         write_q    <= 1'b0;
         io_addr_q  <= '0;
         io_data_q  <= '0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
`ifndef IOARB_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         grant_id_q <= grant_id_d;
         write_q    <= write_d;
         io_addr_q  <= io_addr_d;
         io_data_q  <= io_data_d;
         r0_rdata_q <= r0_rdata_d;
         r1_rdata_q <= r1_rdata_d;
`ifndef IOARB_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign io_write = (state_q == ISSUE) && write_q;
   assign busy     = (state_q != IDLE);
   assign r0_ack   = (state_q == ACK) && !grant_id_q;
   assign r1_ack   = (state_q == ACK) &&  grant_id_q;
   assign grant_id = grant_id_q;
   assign io_addr  = io_addr_q;
   assign io_data  = io_data_q;
   assign r0_rdata = r0_rdata_q;
   assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-timeline model.
module tb_io_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          sync_rst;
   logic          r0_req, r1_req, r0_write, r1_write;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata, io_data_out;
   logic          r0_ack, r1_ack, io_write, busy, grant_id;
   logic [DW-1:0] r0_rdata, r1_rdata, io_data;
   logic [AW-1:0] io_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   io_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IO_LAT(LAT)) dut (
      .clk(clk), .sync_rst(sync_rst),
      .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata),
      .io_addr(io_addr), .io_data(io_data), .io_write(io_write),
      .io_data_out(io_data_out), .busy(busy), .grant_id(grant_id)
   );

   // Model: a granted transaction occupies cycles t=1 (issue) .. t=LAT+2 (ack) after its grant edge
   bit            m_active = 1'b0;
   int            m_t      = 0;
   bit            m_gid    = 1'b0;
   bit            m_last   = 1'b1;
   bit            m_write  = 1'b0;
   logic [AW-1:0] m_addr   = '0;
   logic [DW-1:0] m_wdata  = '0;
   logic [DW-1:0] m_rdata0 = '0;
   logic [DW-1:0] m_rdata1 = '0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit port, input bit req, input bit wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (port) begin
         r1_req = req; r1_write = wr; r1_addr = addr; r1_wdata = wdata;
      end else begin
         r0_req = req; r0_write = wr; r0_addr = addr; r0_wdata = wdata;
      end
   endtask

   task automatic m_grant(input bit p);
      m_active = 1'b1;
      m_t      = 1;
      m_gid    = p;
      m_last   = p;
      m_write  = p ? r1_write : r0_write;
      m_addr   = p ? r1_addr  : r0_addr;
      m_wdata  = p ? r1_wdata : r0_wdata;
   endtask

   function automatic bit nextReq(input logic cur, input logic ack);
      if (cur && ack) return bit'($urandom_range(0, 1));
      if (cur)        return $urandom_range(0, 31) != 0;
      return $urandom_range(0, 9) < 3;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge sync_rst);
         if (sync_rst) begin
            m_active = 1'b0; m_t = 0; m_gid = 1'b0; m_last = 1'b1; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
         end else if (m_active && m_t == LAT + 2) begin
            if (m_gid ? r0_req : r1_req) m_grant(!m_gid);
            else                         m_active = 1'b0;
         end else if (m_active) begin
            if (m_t == LAT + 1 && !m_write) begin
               if (m_gid) m_rdata1 = io_data_out;
               else       m_rdata0 = io_data_out;
            end
            m_t++;
         end else if (r0_req || r1_req) begin
            if (r0_req && r1_req) begin
`ifdef IOARB_PRIO_EN
               m_grant(1'b0);
`else
               m_grant(!m_last);
`endif
            end else begin
               m_grant(r1_req);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         checkOutput("busy",     busy,     32'(m_active));
         checkOutput("io_write", io_write, 32'(m_active && m_t == 1 && m_write));
         checkOutput("r0_ack",   r0_ack,   32'(m_active && m_t == LAT + 2 && !m_gid));
         checkOutput("r1_ack",   r1_ack,   32'(m_active && m_t == LAT + 2 &&  m_gid));
         checkOutput("io_addr",  io_addr,  32'(m_addr));
         checkOutput("io_data",  io_data,  32'(m_wdata));
         checkOutput("grant_id", grant_id, 32'(m_gid));
         checkOutput("r0_rdata", r0_rdata, 32'(m_rdata0));
         checkOutput("r1_rdata", r1_rdata, 32'(m_rdata1));
      end
   end

   initial begin
      sync_rst = 1'b1;
      applyStimulus(0, 0, 0, '0, '0);
      applyStimulus(1, 0, 0, '0, '0);
      io_data_out = '0;
      tick();
      tick();
      checkOutput("rst_busy",     busy,     0);
      checkOutput("rst_io_addr",  io_addr,  0);
      checkOutput("rst_io_write", io_write, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_r0_rdata", r0_rdata, 0);
      sync_rst = 1'b0;

      // Single read on port 0, io_data_out changes every cycle to pin the capture cycle
      io_data_out = 16'h0011;
      applyStimulus(0, 1, 0, 16'h0002, 16'h9999);
      tick();
      checkOutput("rd_issue_addr",  io_addr,  16'h0002);
      checkOutput("rd_issue_busy",  busy,     1);
      checkOutput("rd_issue_write", io_write, 0);
      r0_addr = 16'hFFFF;
      tick(); io_data_out = 16'h0022;
      tick(); io_data_out = 16'h0033;
      tick(); io_data_out = 16'h00A5;
      checkOutput("rd_no_early_ack", r0_ack, 0);
      tick(); io_data_out = 16'h0055;
      checkOutput("rd_ack",      r0_ack,   1);
      checkOutput("rd_rdata",    r0_rdata, 16'h00A5);
      checkOutput("rd_addr_hold", io_addr, 16'h0002);
      r0_req = 1'b0;
      tick();
      checkOutput("rd_idle", busy, 0);

      // Single write on port 1
      applyStimulus(1, 1, 1, 16'h0001, 16'h1234);
      tick();
      checkOutput("wr_io_write", io_write, 1);
      checkOutput("wr_io_data",  io_data,  16'h1234);
      checkOutput("wr_io_addr",  io_addr,  16'h0001);
      checkOutput("wr_grant_id", grant_id, 1);
      r1_wdata = 16'hBEEF;
      tick();
      checkOutput("wr_write_once", io_write, 0);
      tick(); tick(); tick();
      checkOutput("wr_ack",   r1_ack,   1);
      checkOutput("wr_rdata", r1_rdata, 16'h0000);
      r1_req = 1'b0;
      tick();

      // Tie right after reset: r0 first, then strict alternation through the ACK state
      sync_rst = 1'b1;
      tick();
      sync_rst = 1'b0;
      applyStimulus(0, 1, 0, 16'h0010, 16'h0);
      applyStimulus(1, 1, 0, 16'h0020, 16'h0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) checkOutput("tie_first_grant", grant_id, 0);
         checkOutput("tie_r0_ack", r0_ack, 32'(c % 10 == 5));
         checkOutput("tie_r1_ack", r1_ack, 32'(c % 10 == 0));
      end
      r0_req = 1'b0;
      r1_req = 1'b0;
      tick();

      // Reset during the issue cycle of a write aborts it without an ack
      applyStimulus(0, 1, 1, 16'h0040, 16'h4444);
      tick();
      checkOutput("rst_mid_write_hi", io_write, 1);
      #1 sync_rst = 1'b1;
      #1;
      checkOutput("rst_mid_io_write", io_write, 0);
      checkOutput("rst_mid_busy",     busy,     0);
      checkOutput("rst_mid_io_addr",  io_addr,  0);
      checkOutput("rst_mid_io_data",  io_data,  0);
      r0_req = 1'b0;
      tick();
      sync_rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         checkOutput("rst_mid_no_ack", r0_ack, 0);
      end
      checkOutput("rst_mid_rdata", r0_rdata, 0);
      io_data_out = 16'h5A5A;
      applyStimulus(0, 1, 0, 16'h0050, 16'h0);
      for (int c = 0; c < 5; c++) tick();
      checkOutput("post_rst_ack",   r0_ack,   1);
      checkOutput("post_rst_rdata", r0_rdata, 16'h5A5A);
      r0_req = 1'b0;
      tick();

      // Port 1 withdraws its request in the issue cycle; ack still arrives
      applyStimulus(1, 1, 0, 16'h0060, 16'h0);
      tick();
      r1_req = 1'b0;
      tick(); tick(); tick(); tick();
      checkOutput("drop_ack", r1_ack, 1);
      tick();
      checkOutput("drop_idle", busy, 0);

      // Randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 4000; i++) begin
         tick();
         if ($urandom_range(0, 299) == 0) begin
            sync_rst = 1'b1;
            r0_req = 1'b0;
            r1_req = 1'b0;
            tick();
            sync_rst = 1'b0;
         end else begin
            io_data_out = DW'($urandom);
            r0_req   = nextReq(r0_req, r0_ack);
            r0_write = 1'($urandom);
            r0_addr  = AW'($urandom);
            r0_wdata = DW'($urandom);
            r1_req   = nextReq(r1_req, r1_ack);
            r1_write = 1'($urandom);
            r1_addr  = AW'($urandom);
            r1_wdata = DW'($urandom);
         end
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_arbiter.md
# io_arbiter

Shares the single `io` peripheral port (address, write data, write strobe, read data) between two requesters: the CPU core (port 0) and an auxiliary master such as a debug loader or DMA engine (port 1). Each request is granted with round-robin arbitration. The block sequences each request as a fixed-length transaction against the `io` block and returns a one-cycle acknowledge with captured read data. It sits between the core/aux masters and `io`, clocked by the same gated clock.

## Interface
- `ADDR_W`, 16, io address width
- `DATA_W`, 16, io data width
- `IO_LAT`, 1, cycles from address presented to `io_data_out` valid; legal range 1..15
- `clk`  input  1  rising-edge clock
- `sync_rst`  input  1  reset; one clock; reset is asynchronous and active-high
- `r0_req`, `r1_req`  input  1  transaction request; held high until matching ack
- `r0_write`, `r1_write`  input  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  input  ADDR_W  target address
- `r0_wdata`, `r1_wdata`  input  DATA_W  write data
- `r0_ack`, `r1_ack`  output  1  one-cycle completion pulse
- `r0_rdata`, `r1_rdata`  output  DATA_W  read result, valid from ack cycle, held until next read ack on that port
- `io_addr`  output  ADDR_W  to io `addr`
- `io_data`  output  DATA_W  to io `data`
- `io_write`  output  1  to io `write`
- `io_data_out`  input  DATA_W  from io `data_out`
- `busy`  output  1  transaction in progress (state != IDLE)
- `grant_id`  output  1  requester owning the current/last transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any `rN_req`, pick the winner, latch its write/addr/wdata, set `grant_id`, go to ISSUE. If none, stay.
- Arbitration: if only one requester is asking, it wins. On a tie, the requester not equal to `last_grant` wins. `last_grant` updates on each grant.
- ISSUE (1 cycle): drive latched `io_addr`/`io_data`; `io_write`=1 only for writes. Load wait counter with `IO_LAT`; go to WAIT.
- WAIT: decrement counter and hold `io_addr`. `io_write`=0. On the cycle the counter is 1, capture `io_data_out` into the granted port's rdata (reads only). Then go to ACK.
- ACK (1 cycle): pulse the granted `rN_ack`. The granted requester's `req` is ignored this cycle. If the other requester's `req` is high, grant it and go directly to ISSUE. Otherwise go to IDLE.
- Payload is latched at grant; input changes after grant have no effect on the current transaction.
- `req` dropped before ack: the transaction still completes and the ack is still pulsed.
- Idle outputs: `io_write`=0; `io_addr`/`io_data` hold their last values.
- Wait counter is 4 bits. `IO_LAT`=0 or >15 is illegal and flagged by an elaboration-time `$error`.

## Timing
- Reset values: `io_addr`=0, `io_data`=0, `io_write`=0, `r0_ack`=`r1_ack`=0, `r0_rdata`=`r1_rdata`=0, `busy`=0, `grant_id`=0, `last_grant`=1 (port 0 wins the first tie), state IDLE.
- `sync_rst` asserted mid-transaction aborts it immediately: `io_write` drops asynchronously, and no ack is issued.
- Request sampled in IDLE at edge N:
  - ISSUE during cycle N+1.
  - WAIT during cycles N+2..N+1+IO_LAT.
  - ack high during cycle N+2+IO_LAT (cycle N+3 for IO_LAT=1).
- Back-to-back alternating requests: one transaction every IO_LAT+2 cycles, with no IDLE cycle between them.
- Same requester re-requesting: passes through IDLE, so one transaction every IO_LAT+3 cycles.
- `io_write` is high for exactly one cycle per write transaction.

## Configuration
- `IOARB_PRIO_EN` defined:
  - fixed priority; port 0 wins every tie in IDLE;
  - `last_grant` is unused;
  - the ACK-state rule (granted requester ignored) is unchanged, so port 1 can still follow port 0 directly.
- `IOARB_PRIO_EN` undefined: round-robin as described above.

## Test plan
- Single read: r0 read addr 0x0002 with `io_data_out`=0x00A5, IO_LAT=1 -> `io_addr`=0x0002 from cycle N+1; `r0_ack` at N+3; `r0_rdata`=0x00A5; `io_write` never high.
- Single write: r1 write addr 0x0001 data 0x1234 -> `io_write`=1 only in cycle N+1 with `io_data`=0x1234; `r1_ack` at N+3; `r1_rdata` unchanged.
- Tie after reset: r0 and r1 assert together and hold -> grants in order r0, r1, r0, r1, with acks 3 cycles apart (IO_LAT=1). With `IOARB_PRIO_EN`, the order is still r0, r1 alternating via the ACK rule.
- Reset mid-transaction: assert `sync_rst` during WAIT of a write -> all outputs at reset values in the same cycle; no ack; after release a new r0 request completes normally.
- Latency sweep: IO_LAT=3, r0 read -> ack at N+5; rdata equals the `io_data_out` value present in cycle N+4.
- Dropped request: r1 deasserts req in the ISSUE cycle -> `r1_ack` still pulses at N+3; FSM returns to IDLE.
